// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the 12-bit to 8-bit floating-point
// converter front-end.
package fp_pkg;

  localparam int IN_W    = 12;
  localparam int EXP_W   = 3;
  localparam int SIG_W   = 4;
  localparam int EXP_MAX = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage : fp_pkg

// File: rtl/fp_abs.sv
// Combinational two's-complement to sign-magnitude conversion. The most
// negative input saturates to the largest positive magnitude and raises sat.
module fp_abs
  import fp_pkg::*;
(
  input  logic [IN_W-1:0] d,
  output logic            s,
  output logic [IN_W-1:0] mag,
  output logic            sat
);

  localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W-1:0] MOST_POS = {1'b0, {(IN_W-1){1'b1}}};

  always_comb begin
    s   = d[IN_W-1];
    sat = (d == MOST_NEG);
    // -2048 has no positive twin in 12 bits, so clamp it instead of wrapping.
    if (sat)
      mag = MOST_POS;
    else if (s)
      mag = ~d + 1'b1;
    else
      mag = d;
  end

endmodule : fp_abs

// File: rtl/fp_normalize.sv
// Serial normaliser: one left shift per cycle until the leading one reaches
// bit 10 or the exponent hits zero. Define FP_NORMALIZE_SAT_FLAG_EN for the sat output.
module fp_normalize
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] sig,
  output logic             fifth
`ifdef FP_NORMALIZE_SAT_FLAG_EN
  ,
  output logic             sat
`endif
);

  norm_state_t      state, state_nxt;
  logic [IN_W-1:0]  shreg;
  logic [EXP_W-1:0] exp_cnt;
  logic             s_q;
  logic             abs_s;
  logic [IN_W-1:0]  abs_mag;
  logic             abs_sat;
  logic             accept;
  logic             norm_done;

  fp_abs u_abs (
    .d   (d),
    .s   (abs_s),
    .mag (abs_mag),
    .sat (abs_sat)
  );

  assign accept    = in_valid && in_ready;
  assign norm_done = shreg[IN_W-2] || (exp_cnt == '0);

  // NOTE: state and registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = NORM;
      NORM:    if (norm_done) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      exp_cnt <= '0;
      s_q     <= 1'b0;
    end else if (accept) begin
      shreg   <= abs_mag;
      exp_cnt <= EXP_W'(EXP_MAX);
      s_q     <= abs_s;
    end else if (state == NORM && !norm_done) begin
      shreg   <= {shreg[IN_W-2:0], 1'b0};
      exp_cnt <= exp_cnt - 1'b1;
    end
  end

  // Visible outputs load only on the NORM->DONE edge so they stay frozen
  // while the consumer stalls and while the next sample is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= 1'b0;
      exp   <= '0;
      sig   <= '0;
      fifth <= 1'b0;
    end else if (state == NORM && norm_done) begin
      s     <= s_q;
      exp   <= exp_cnt;
      sig   <= shreg[IN_W-2 -: SIG_W];
      fifth <= shreg[IN_W-2-SIG_W];
    end
  end

`ifdef FP_NORMALIZE_SAT_FLAG_EN
  logic sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
      sat   <= 1'b0;
    end else begin
      if (accept)                     sat_q <= abs_sat;
      if (state == NORM && norm_done) sat   <= sat_q;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = abs_sat;
`endif

endmodule : fp_normalize

// File: tb/tb_fp_normalize.sv
// Scoreboard bench for fp_normalize: expectations come from a behavioural
// leading-one model and are popped when out_valid is seen.
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] d;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic [2:0]  exp;
  logic [3:0]  sig;
  logic        fifth;
`ifdef FP_NORMALIZE_SAT_FLAG_EN
  logic        sat;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [3:0] sig;
    logic       fifth;
    logic       sat;
    logic [3:0] lat;
  } exp_t;

  exp_t sb[$];

  fp_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .exp       (exp),
    .sig       (sig),
    .fifth     (fifth)
`ifdef FP_NORMALIZE_SAT_FLAG_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Independent model: find the leading one, pick E so that it lands at sig[3].
  function automatic exp_t model(input logic [11:0] din);
    exp_t        r;
    logic [11:0] m;
    logic [11:0] sh;
    int          p;
    int          e;
    m = (din == 12'h800) ? 12'h7FF : (din[11] ? 12'(-din) : din);
    p = -1;
    for (int i = 0; i < 12; i++) if (m[i]) p = i;
    e = (p > 3) ? p - 3 : 0;
    sh      = m >> e;
    r.s     = din[11];
    r.e     = 3'(e);
    r.sig   = sh[3:0];
    r.fifth = (e > 0) ? m[e-1] : 1'b0;
    r.sat   = (din == 12'h800);
    r.lat   = 4'(1 + 7 - e);
    return r;
  endfunction

  task automatic check_outputs(input string tag, input exp_t x);
    check({tag, ".s"},     32'(s),     32'(x.s));
    check({tag, ".exp"},   32'(exp),   32'(x.e));
    check({tag, ".sig"},   32'(sig),   32'(x.sig));
    check({tag, ".fifth"}, 32'(fifth), 32'(x.fifth));
`ifdef FP_NORMALIZE_SAT_FLAG_EN
    check({tag, ".sat"},   32'(sat),   32'(x.sat));
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 0);
    check({tag, ".in_ready"},  32'(in_ready),  1);
    check({tag, ".s"},         32'(s),         0);
    check({tag, ".exp"},       32'(exp),       0);
    check({tag, ".sig"},       32'(sig),       0);
    check({tag, ".fifth"},     32'(fifth),     0);
`ifdef FP_NORMALIZE_SAT_FLAG_EN
    check({tag, ".sat"},       32'(sat),       0);
`endif
  endtask

  // Drive one sample at a negedge, count edges until out_valid, then stall
  // the consumer for 'hold' cycles while poking in_valid to prove it is ignored.
  task automatic run(input string tag, input logic [11:0] din, input int hold);
    exp_t x;
    int   n;
    int   edges;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, ".in_ready_pre"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    d        = din;
    sb.push_back(model(din));
    @(negedge clk);
    in_valid = 1'b0;
    d        = 12'h5A5;
    check({tag, ".in_ready_busy"}, 32'(in_ready), 0);
    edges = 0;
    while (!out_valid && edges < 20) begin @(negedge clk); edges++; end
    x = sb.pop_front();
    check({tag, ".latency"}, 32'(edges), 32'(x.lat));
    check_outputs(tag, x);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 1);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 0);
      check_outputs({tag, ".hold"}, x);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 32'(out_valid), 0);
    check({tag, ".release_in_ready"}, 32'(in_ready), 1);
    check_outputs({tag, ".after"}, x);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = 12'h000;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run("zero",   12'h000, 0);
    run("d422",   12'h1A6, 0);
    run("most_neg", 12'h800, 0);
    run("minus1", 12'hFFF, 0);
    run("d125_stall", 12'h07D, 5);
    run("max_pos", 12'h7FF, 0);
    run("d8",     12'h008, 1);
    run("d7",     12'h007, 0);

    // Abort a sample mid-normalisation with an asynchronous reset.
    in_valid = 1'b1;
    d        = 12'h001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    check_zero_outputs("abort_after");

    run("after_abort", 12'h001, 0);

    for (int k = 0; k < 20; k++) begin
      run("rand", 12'($urandom), int'($urandom_range(0, 2)));
    end

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

endmodule : tb_fp_normalize
